mod_74x163_n: RTL and testbench

Parametrised synchronous presettable counter: the first sequential member of the 74xx model library, generalising the 74x160/161/163/191 family into one block. WIDTH-bit registered count with synchronous clear, synchronous parallel load, up/down mode, programmable modulus and a cascadable ripple-carry output. It is used standalone or chained through ENT/RCO to build wider counters from identical instances.

---
 rtl/mod_74x163_n_pkg.sv | 18 +
 rtl/mod_74x163_n_tc.sv | 27 ++
 rtl/mod_74x163_n.sv | 65 ++++++
 tb/tb_mod_74x163_n.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mod_74x163_n_pkg.sv
// Shared 74xx definitions: direction
// encoding and parameter range check.
package mod_74x163_n_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic bit params_ok(
    input int w,
    input int m
  );
    longint lim;
    if (w < 1 || w > 31) return 1'b0;
    lim = longint'(1) << w;
    return (m >= 2) && (longint'(m) <= lim);
  endfunction

endpackage

// File: rtl/mod_74x163_n_tc.sv
// Terminal-count and ripple-carry decode
// for the presettable counter.
module mod_74x163_n_tc
  import mod_74x163_n_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             UP,
  input  logic             ENT,
  output logic             TC,
  output logic             RCO
);

  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(MODULUS - 1);

  // Out-of-range Q never equals MAX or 0.
  always_comb begin
    TC = 1'b0;
    if (UP == DIR_UP) TC = (Q == MAX);
    else              TC = (Q == '0);
    RCO = ENT & TC;
  end

endmodule

// File: rtl/mod_74x163_n.sv
// Synchronous presettable up/down counter
// with programmable modulus and RCO cascade.
module mod_74x163_n
  import mod_74x163_n_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  if (!params_ok(WIDTH, MODULUS)) begin : g_bad
    $error("mod_74x163_n: bad WIDTH/MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(MODULUS - 1);

  logic             tc;
  logic             wrap;
  logic [WIDTH-1:0] q_nxt;

  mod_74x163_n_tc #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_tc (
    .Q  (Q),
    .UP (UP),
    .ENT(ENT),
    .TC (tc),
    .RCO(RCO)
  );

  // tc already selects the wrap point for
  // the current direction; out-of-range
  // values wrap the same way.
  assign wrap = tc || (Q > MAX);

  always_comb begin
    q_nxt = Q;
    if (CLR) begin
      q_nxt = '0;
    end else if (LOAD) begin
      q_nxt = D;
    end else if (ENP && ENT) begin
      if (UP == DIR_UP)
        q_nxt = wrap ? '0 : Q + 1'b1;
      else
        q_nxt = wrap ? MAX : Q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    Q <= q_nxt;
  end

endmodule

// File: tb/tb_mod_74x163_n.sv
// Directed bench: vector table plus
// hand sequences for RCO and cascade.
module tb_mod_74x163_n;

  typedef struct {
    logic       clr;
    logic       load;
    logic       enp;
    logic       ent;
    logic       up;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;
    int         sel;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr, load, enp, ent, up;
  logic [3:0] d;
  logic [3:0] q16, q10;
  logic       rco16, rco10;

  logic       c_clr;
  logic [3:0] lo_q, hi_q;
  logic       lo_rco, hi_rco;

  int n_checks = 0;
  int n_err    = 0;

  vec_t tv[$];

  always #5 clk = ~clk;

  mod_74x163_n #(.WIDTH(4), .MODULUS(16)) u16 (
    .CLK(clk), .CLR(clr), .LOAD(load),
    .ENP(enp), .ENT(ent), .UP(up), .D(d),
    .Q(q16), .RCO(rco16)
  );

  mod_74x163_n #(.WIDTH(4), .MODULUS(10)) u10 (
    .CLK(clk), .CLR(clr), .LOAD(load),
    .ENP(enp), .ENT(ent), .UP(up), .D(d),
    .Q(q10), .RCO(rco10)
  );

  mod_74x163_n #(.WIDTH(4), .MODULUS(10)) ulo (
    .CLK(clk), .CLR(c_clr), .LOAD(1'b0),
    .ENP(1'b1), .ENT(1'b1), .UP(1'b1),
    .D(4'd0), .Q(lo_q), .RCO(lo_rco)
  );

  mod_74x163_n #(.WIDTH(4), .MODULUS(10)) uhi (
    .CLK(clk), .CLR(c_clr), .LOAD(1'b0),
    .ENP(1'b1), .ENT(lo_rco), .UP(1'b1),
    .D(4'd0), .Q(hi_q), .RCO(hi_rco)
  );

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic add(
    input logic c, input logic l,
    input logic p, input logic t,
    input logic u, input logic [3:0] dd,
    input logic [3:0] eq, input logic er,
    input int s
  );
    vec_t v;
    v.clr = c;  v.load = l; v.enp = p;
    v.ent = t;  v.up = u;   v.d = dd;
    v.q = eq;   v.rco = er; v.sel = s;
    tv.push_back(v);
  endtask

  task automatic apply_row(input int i);
    vec_t v;
    string nm;
    v = tv[i];
    clr = v.clr; load = v.load;
    enp = v.enp; ent = v.ent;
    up = v.up;   d = v.d;
    @(posedge clk);
    #1;
    nm = $sformatf("vec%0d", i);
    if (v.sel == 0) begin
      check({nm, " q16"}, 32'(q16), 32'(v.q));
      check({nm, " rco16"}, 32'(rco16), 32'(v.rco));
    end else begin
      check({nm, " q10"}, 32'(q10), 32'(v.q));
      check({nm, " rco10"}, 32'(rco10), 32'(v.rco));
    end
  endtask

  initial begin
    int n16;
    int cnt;
    logic       prev_rco;
    logic [3:0] prev_hi;
    logic [3:0] exp_hi;

    // MODULUS=16 rows
    add(1,0,0,1,0, 0, 0,1, 0);
    add(1,0,0,1,1, 0, 0,0, 0);
    for (int k = 1; k <= 16; k++)
      add(0,0,1,1,1, 0, 4'(k), k == 15, 0);
    add(1,1,1,1,1, 7, 0,0, 0);
    add(0,1,1,1,1, 7, 7,0, 0);
    add(0,1,0,1,1, 5, 5,0, 0);
    for (int k = 0; k < 3; k++)
      add(0,0,0,1,1, 0, 5,0, 0);
    add(0,1,1,0,1, 15, 15,0, 0);
    add(0,0,1,0,1, 0, 15,0, 0);
    n16 = tv.size();

    // MODULUS=10 rows
    add(0,1,0,1,0, 2, 2,0, 1);
    add(0,0,1,1,0, 0, 1,0, 1);
    add(0,0,1,1,0, 0, 0,1, 1);
    add(0,0,1,1,0, 0, 9,0, 1);
    add(0,0,1,1,0, 0, 8,0, 1);
    add(0,1,0,1,1, 12, 12,0, 1);
    add(0,0,1,1,1, 0, 0,0, 1);
    add(0,1,0,1,0, 13, 13,0, 1);
    add(0,0,1,1,0, 0, 9,0, 1);
    add(0,0,0,1,1, 0, 9,1, 1);
    add(0,0,1,1,1, 0, 0,0, 1);

    clr = 1; load = 0; enp = 0;
    ent = 0; up = 1; d = 0;
    c_clr = 1;
    @(negedge clk);

    for (int i = 0; i < n16; i++)
      apply_row(i);

    // RCO follows ENT within the cycle
    enp = 0; ent = 1;
    #1;
    check("rco ent rise", 32'(rco16), 32'd1);
    check("q15 hold", 32'(q16), 32'd15);
    ent = 0;
    #1;
    check("rco ent fall", 32'(rco16), 32'd0);
    up = 0; ent = 1;
    #1;
    check("rco dir swap", 32'(rco16), 32'd0);

    for (int i = n16; i < tv.size(); i++)
      apply_row(i);

    // two-stage decade cascade
    c_clr = 1;
    @(posedge clk);
    #1;
    c_clr = 0;
    check("casc reset", 32'(hi_q * 10 + lo_q), 32'd0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      prev_rco = lo_rco;
      prev_hi  = hi_q;
      @(posedge clk);
      #1;
      cnt = (cnt + 1) % 100;
      exp_hi = prev_rco ?
        4'((prev_hi + 1) % 10) : prev_hi;
      check($sformatf("casc cnt%0d", k),
            32'(hi_q * 10 + lo_q), 32'(cnt));
      check($sformatf("casc hi%0d", k),
            32'(hi_q), 32'(exp_hi));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
